// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: operand forwarding, load-use bubbles, memory-wait stalls and stall counting.
module hazard_forward_unit #(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_SRC*REG_AW-1:0]   id_rs_addr,
  input  logic [NUM_SRC-1:0]          id_rs_used,
  input  logic [NUM_SRC*REG_AW-1:0]   ex_rs_addr,
  input  logic                        id_ex_memRead,
  input  logic [REG_AW-1:0]           id_ex_rd,
  input  logic                        EX_MEM_regWrite,
  input  logic                        EX_MEM_memRead,
  input  logic [REG_AW-1:0]           EX_MEM_rd,
  input  logic                        MEM_WB_regWrite,
  input  logic [REG_AW-1:0]           MEM_WB_rd,
  input  logic                        mem_ready,
  output logic [2*NUM_SRC-1:0]        fwd_sel,
  output logic [REG_AW-1:0]           wb_hold_rd,
  output logic                        hold_en,
  output logic                        stall_pc,
  output logic                        stall_ifid,
  output logic                        bubble_idex,
  output logic                        stall_all,
  output logic                        mem_timeout,
  output logic [CNT_W-1:0]            stall_cycles
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic [REG_AW-1:0] hold_rd;
  logic [CNT_W-1:0] cnt;
  logic hold_valid, tmo, raw_stall, lu, ex_ok, wb_ok;
  logic [2*NUM_SRC-1:0] fwd_raw;
  assign raw_stall = EX_MEM_memRead & ~mem_ready;
  assign ex_ok = EX_MEM_regWrite & ~EX_MEM_memRead & |EX_MEM_rd;
  assign wb_ok = MEM_WB_regWrite & |MEM_WB_rd;
  always_comb begin
    lu = 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      lu = lu | (id_ex_memRead & |id_ex_rd & id_rs_used[i] &
                 (id_rs_addr[i*REG_AW +: REG_AW] == id_ex_rd));
  end
  // Priority: youngest producer first, the WB-hold copy last.
  always_comb begin
    fwd_raw = '0;
    for (int i = 0; i < NUM_SRC; i++)
      fwd_raw[2*i +: 2] = (ex_ok && EX_MEM_rd == ex_rs_addr[i*REG_AW +: REG_AW]) ? 2'b01 :
                          (wb_ok && MEM_WB_rd == ex_rs_addr[i*REG_AW +: REG_AW]) ? 2'b10 :
                          (hold_valid && hold_rd == ex_rs_addr[i*REG_AW +: REG_AW]) ? 2'b11 : 2'b00;
  end
  always_comb begin
    state_nxt = state;
    wait_nxt = wait_cnt;
    if (state == RUN) begin
      state_nxt = raw_stall ? MEM_WAIT : RUN;
      wait_nxt = raw_stall ? WW'(1) : wait_cnt;
    end else if (mem_ready) begin
      state_nxt = RUN;
      wait_nxt = '0;
    end else if (raw_stall && wait_cnt != WW'(MAX_WAIT)) begin
      wait_nxt = wait_cnt + WW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      wait_cnt <= '0;
      hold_valid <= 1'b0;
      hold_rd <= '0;
      tmo <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      wait_cnt <= wait_nxt;
      if (!raw_stall) begin
        hold_valid <= wb_ok;
        hold_rd <= MEM_WB_rd;
      end
      if (raw_stall && wait_cnt == WW'(MAX_WAIT)) tmo <= 1'b1;
      if ((raw_stall | lu) && ~&cnt) cnt <= cnt + CNT_W'(1);
    end
  end
  assign fwd_sel      = rst_n ? fwd_raw : '0;
  assign wb_hold_rd   = rst_n ? hold_rd : '0;
  assign hold_en      = rst_n & ~raw_stall;
  assign stall_all    = rst_n & raw_stall;
  assign stall_pc     = rst_n & (raw_stall | lu);
  assign stall_ifid   = rst_n & (raw_stall | lu);
  assign bubble_idex  = rst_n & lu & ~raw_stall;
  assign mem_timeout  = rst_n & tmo;
  assign stall_cycles = rst_n ? cnt : '0;
endmodule
